// File: rtl/full_adder_pkg.sv
// Shared types and reference evaluation for the full_adder block.
package full_adder_pkg;

  localparam int FA_MAX_LANES = 64;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_result_t;

  function automatic fa_result_t fa_eval(input logic a, input logic b, input logic cin);
    fa_result_t r;
    r.sum  = a ^ b ^ cin;
    r.cout = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder (3:2 compressor).
module full_adder_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  fa_result_t res;

  always_comb res = fa_eval(a, b, cin);

  assign sum  = res.sum;
  assign cout = res.cout;

endmodule

// File: rtl/full_adder.sv
// LANES-wide full adder with same-cycle and registered, valid-qualified outputs.
// Optional macro FULL_ADDER_CARRY_CHAIN_EN turns the lanes into a ripple-carry adder.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] cin,
  input  logic             in_valid,
  output logic [LANES-1:0] sum_comb,
  output logic [LANES-1:0] cout_comb,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] cout,
  output logic             out_valid
);

  logic [LANES-1:0] cin_eff;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef FULL_ADDER_CARRY_CHAIN_EN
    // Lane 0 takes the external carry; every other lane takes its neighbour's carry-out.
    if (i == 0) begin : g_first
      assign cin_eff[i] = cin[0];
    end else begin : g_rest
      assign cin_eff[i] = cout_comb[i-1];
    end
`else
    assign cin_eff[i] = cin[i];
`endif

    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (cin_eff[i]),
      .sum  (sum_comb[i]),
      .cout (cout_comb[i])
    );
  end

  // Result registers hold their value while in_valid is low; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_comb;
        cout <= cout_comb;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: directed vectors on narrow instances, randomized 64-lane traffic.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // LANES=1 instance
  logic [0:0] a1 = '0, b1 = '0, c1 = '0;
  logic       v1 = 1'b0;
  logic [0:0] sc1, cc1, s1, co1;
  logic       ov1;
  // LANES=4 instance
  logic [3:0] a4 = '0, b4 = '0, c4 = '0;
  logic       v4 = 1'b0;
  logic [3:0] sc4, cc4, s4, co4;
  logic       ov4;
  // LANES=64 instance
  logic [63:0] aw = '0, bw = '0, cw = '0;
  logic        vw = 1'b0;
  logic [63:0] scw, ccw, sw, cow;
  logic        ovw;

  full_adder #(.LANES(1)) u1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
    .sum_comb(sc1), .cout_comb(cc1), .sum(s1), .cout(co1), .out_valid(ov1));
  full_adder #(.LANES(4)) u4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(c4), .in_valid(v4),
    .sum_comb(sc4), .cout_comb(cc4), .sum(s4), .cout(co4), .out_valid(ov4));
  full_adder #(.LANES(64)) uw (.clk(clk), .rst_n(rst_n), .a(aw), .b(bw), .cin(cw), .in_valid(vw),
    .sum_comb(scw), .cout_comb(ccw), .sum(sw), .cout(cow), .out_valid(ovw));

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane counts its ones; in chain mode the lanes are one binary addition.
  function automatic exp_t ref_add(input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] c, input int n);
    exp_t r;
    r.s = '0;
    r.c = '0;
`ifdef FULL_ADDER_CARRY_CHAIN_EN
    begin
      logic [63:0] m;
      logic [64:0] t;
      m = '0;
      for (int i = 0; i < n; i++) begin
        m = m | (64'd1 << i);
        t = {1'b0, a & m} + {1'b0, b & m} + {64'd0, c[0]};
        r.s[i] = t[i];
        r.c[i] = t[i+1];
      end
    end
`else
    for (int i = 0; i < n; i++) begin
      int k;
      k = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r.s[i] = k[0];
      r.c[i] = k[1];
    end
`endif
    return r;
  endfunction

  // Monitor for the wide instance: pop on every presented result, otherwise expect held values.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ovw) begin
        if (sb_q.size() == 0) begin
          chk("w_unexpected_valid", 64'd1, 64'd0);
        end else begin
          last_exp = sb_q.pop_front();
          chk("w_reg_sum", sw, last_exp.s);
          chk("w_reg_cout", cow, last_exp.c);
        end
      end else begin
        chk("w_hold_sum", sw, last_exp.s);
        chk("w_hold_cout", cow, last_exp.c);
      end
    end
  end

  initial begin
    exp_t e, e_prev;
    logic [63:0] ta, tb, tc;
    logic [1:0] tt [8];
    last_exp.s = '0;
    last_exp.c = '0;

    // Reset state
    #12;
    chk("rst_ov1", {63'd0, ov1}, 64'd0);
    chk("rst_s4", {60'd0, s4}, 64'd0);
    chk("rst_co4", {60'd0, co4}, 64'd0);
    chk("rst_ovw", {63'd0, ovw}, 64'd0);
    chk("rst_sw", sw, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LANES=1 sweep: truth table 0,1,1,2,1,2,2,3 on both paths
    tt = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      if (v > 0) begin
        chk("u1_reg", {62'd0, co1, s1}, {62'd0, tt[v-1]});
        chk("u1_ov", {63'd0, ov1}, 64'd1);
      end
      ta = 64'(v);
      a1 = ta[2];
      b1 = ta[1];
      c1 = ta[0];
      v1 = 1'b1;
      #1;
      chk("u1_comb", {62'd0, cc1, sc1}, {62'd0, tt[v]});
    end
    @(posedge clk);
    #1;
    chk("u1_reg_last", {62'd0, co1, s1}, {62'd0, tt[7]});
    v1 = 1'b0;

    // LANES=4 directed vector
    a4 = 4'b1010;
    b4 = 4'b0110;
    c4 = 4'b0011;
    v4 = 1'b1;
    #1;
`ifdef FULL_ADDER_CARRY_CHAIN_EN
    chk("u4_comb_sum", {60'd0, sc4}, 64'h1);
    chk("u4_comb_cout", {60'd0, cc4}, 64'he);
`else
    chk("u4_comb_sum", {60'd0, sc4}, 64'hf);
    chk("u4_comb_cout", {60'd0, cc4}, 64'h2);
`endif
    @(posedge clk);
    #1;
    v4 = 1'b0;
`ifdef FULL_ADDER_CARRY_CHAIN_EN
    chk("u4_reg_sum", {60'd0, s4}, 64'h1);
    chk("u4_reg_cout", {60'd0, co4}, 64'he);
`else
    chk("u4_reg_sum", {60'd0, s4}, 64'hf);
    chk("u4_reg_cout", {60'd0, co4}, 64'h2);
`endif
    chk("u4_ov_cap", {63'd0, ov4}, 64'd1);
    e_prev.s = {60'd0, s4};
    e_prev.c = {60'd0, co4};
    e_prev = ref_add(64'ha, 64'h6, 64'h3, 4);

    // Hold with in_valid low while inputs keep changing
    for (int k = 0; k < 3; k++) begin
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      c4 = 4'($urandom);
      @(posedge clk);
      #1;
      chk("u4_hold_sum", {60'd0, s4}, e_prev.s);
      chk("u4_hold_cout", {60'd0, co4}, e_prev.c);
      chk("u4_hold_ov", {63'd0, ov4}, 64'd0);
    end

    // Async reset between edges while a result is valid
    a4 = 4'b0111;
    b4 = 4'b0101;
    c4 = 4'b1001;
    v4 = 1'b1;
    @(posedge clk);
    #1;
    chk("u4_ov_pre_rst", {63'd0, ov4}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("u4_rst_sum", {60'd0, s4}, 64'd0);
    chk("u4_rst_cout", {60'd0, co4}, 64'd0);
    chk("u4_rst_ov", {63'd0, ov4}, 64'd0);
    e = ref_add(64'h7, 64'h5, 64'h9, 4);
    chk("u4_rst_comb", {56'd0, cc4, sc4}, {56'd0, e.c[3:0], e.s[3:0]});
    @(posedge clk);
    #1;
    chk("u4_in_rst_ov", {63'd0, ov4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("u4_post_rst_ov", {63'd0, ov4}, 64'd1);
    chk("u4_post_rst_reg", {56'd0, co4, s4}, {56'd0, e.c[3:0], e.s[3:0]});
    v4 = 1'b0;

    // Randomized 64-lane traffic through the scoreboard
    @(posedge clk);
    mon_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk);
      #2;
      ta = {$urandom, $urandom};
      tb = {$urandom, $urandom};
      tc = {$urandom, $urandom};
      aw = ta;
      bw = tb;
      cw = tc;
      vw = ($urandom_range(0, 3) != 0);
      e = ref_add(ta, tb, tc, 64);
      if (vw) sb_q.push_back(e);
      #1;
      chk("w_comb_sum", scw, e.s);
      chk("w_comb_cout", ccw, e.c);
    end
    @(posedge clk);
    #2;
    vw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("w_queue_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
